// File: rtl/timestamp_recorder.sv
// Profiling timestamp recorder: stamps COMM_STAMP commands with a cycle counter, buffers them
// in a FIFO and drains them over an AXI4-Stream master. Optional build macro: TS_SEQ_TAG_EN.
module timestamp_recorder #(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  command,
  output logic [63:0] outTDATA,
  output logic        outTVALID,
  input  logic        outTREADY,
  output logic        done,
  output logic        overflow,
  output logic [15:0] dropCount
);

  // Command encoding shared with the command unit (0 is COMM_NOP)
  localparam logic [3:0] COMM_STAMP   = 4'd1;
  localparam logic [3:0] COMM_HOLD    = 4'd2;
  localparam logic [3:0] COMM_RELEASE = 4'd3;
  localparam logic [3:0] COMM_FINISH  = 4'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int AW = $clog2(DEPTH);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]          mem [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          count_q;
  logic                 pend_q;
  logic                 ovf_q;
  logic [15:0]          drop_q;
  logic                 cap, push, pop, drop, full;
  logic [63:0]          word;

`ifdef TS_SEQ_TAG_EN
  logic [15:0] seq_q;
  assign word = {seq_q, 48'(cnt_q)};
`else
  assign word = 64'(cnt_q);
`endif

  // A beat already offered when HOLD lands must stay valid until taken (pend_q)
  assign outTVALID = (count_q != '0) && (state_q != S_IDLE) && ((state_q != S_HELD) || pend_q);
  assign outTDATA  = outTVALID ? mem[rd_q] : '0;
  assign pop       = outTVALID && outTREADY;
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign cap       = ((state_q == S_RUN) || (state_q == S_HELD)) && (command == COMM_STAMP);
  assign push      = cap && (!full || pop);
  assign drop      = cap && !push;
  assign done      = (state_q == S_IDLE);
  assign overflow  = ovf_q;
  assign dropCount = drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != S_IDLE) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (command == COMM_FINISH)    state_d = S_DRAIN;
        else if (command == COMM_HOLD) state_d = S_HELD;
      end
      S_HELD: begin
        if (command == COMM_FINISH)       state_d = S_DRAIN;
        else if (command == COMM_RELEASE) state_d = S_RUN;
      end
      default: begin
        // Leave as the last beat transfers so done rises on the following cycle
        if ((count_q == '0) || ((count_q == (AW+1)'(1)) && pop)) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= outTVALID && !outTREADY;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if ((state_q == S_IDLE) && start) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else if (drop) begin
        ovf_q  <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

`ifdef TS_SEQ_TAG_EN
  // Dropped captures still consume an index so gaps expose drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              seq_q <= '0;
    else if ((state_q == S_IDLE) && start)   seq_q <= '0;
    else if (cap)                            seq_q <= seq_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= word;
  end

endmodule

// File: tb/tb_timestamp_recorder.sv
// Directed bench for timestamp_recorder (DEPTH=4, untagged): scoreboard queue of expected beats.
module tb_timestamp_recorder;

  localparam logic [3:0] NOP = 4'd0, STAMP = 4'd1, HOLD = 4'd2, RELEASE = 4'd3, FINISH = 4'd4;

  logic        clk, rst_n, start, outTVALID, outTREADY, done, overflow;
  logic [3:0]  command;
  logic [63:0] outTDATA;
  logic [15:0] dropCount;

  timestamp_recorder #(.DEPTH(4), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .command(command),
    .outTDATA(outTDATA), .outTVALID(outTVALID), .outTREADY(outTREADY),
    .done(done), .overflow(overflow), .dropCount(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [63:0]  exp_q [$];
  logic         prev_stall = 1'b0;
  logic [63:0]  prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Beat monitor: pops the scoreboard and checks AXI-Stream stability under backpressure
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("axis_valid_held", 64'(outTVALID), 64'd1);
        check("axis_data_held", outTDATA, prev_data);
      end
      if (outTVALID && outTREADY) begin
        if (exp_q.size() == 0) check("beat_expected", 64'(outTVALID && 1'b0), 64'd1);
        else check("beat", outTDATA, exp_q.pop_front());
      end
      prev_stall = outTVALID && !outTREADY;
      prev_data  = outTDATA;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic cmd(input logic [3:0] c);
    command = c;
    step();
    command = NOP;
  endtask

  task automatic stamp(input bit accept);
    command = STAMP;
    if (accept) exp_q.push_back(64'(cyc));
    step();
    command = NOP;
  endtask

  task automatic drain_wait(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
    check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    logic [63:0] first;
    bit          seen;
    bit          last;
    rst_n = 1'b0; start = 1'b0; command = NOP; outTREADY = 1'b0;
    #3;
    check("rst_done", 64'(done), 64'd1);
    check("rst_valid", 64'(outTVALID), 64'd0);
    check("rst_data", outTDATA, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_dropcount", 64'(dropCount), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic capture: stamps at counter 5 and 9
    outTREADY = 1'b1;
    do_start();
    check("run_not_done", 64'(done), 64'd0);
    while (cyc < 5) step();
    check("no_early_valid", 64'(outTVALID), 64'd0);
    stamp(1);
    check("fwft_valid", 64'(outTVALID), 64'd1);
    check("fwft_data", outTDATA, 64'd5);
    while (cyc < 9) step();
    stamp(1);
    drain_wait(10);

    // HOLD gates draining; RELEASE drains in order
    cmd(HOLD);
    for (int i = 0; i < 3; i++) begin
      stamp(1);
      check("held_no_valid", 64'(outTVALID), 64'd0);
    end
    cmd(RELEASE);
    drain_wait(10);

    // Overflow while held: 6 stamps into a 4-deep FIFO
    check("pre_overflow", 64'(overflow), 64'd0);
    cmd(HOLD);
    for (int i = 0; i < 6; i++) stamp(i < 4);
    check("overflow_set", 64'(overflow), 64'd1);
    check("dropcount_2", 64'(dropCount), 64'd2);
    check("overflow_held_valid", 64'(outTVALID), 64'd0);
    cmd(RELEASE);
    drain_wait(10);

    // FINISH with 3 entries and toggling READY
    cmd(HOLD);
    for (int i = 0; i < 3; i++) stamp(1);
    cmd(FINISH);
    check("drain_not_done", 64'(done), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      last = outTVALID && outTREADY && (exp_q.size() == 1);
      command = (i == 1) ? STAMP : NOP;
      step();
      command = NOP;
      outTREADY = ~outTREADY;
      if (last) begin
        check("done_after_last", 64'(done), 64'd1);
        seen = 1'b1;
      end
    end
    check("last_beat_seen", 64'(seen), 64'd1);
    check("finish_queue_empty", 64'(exp_q.size()), 64'd0);
    outTREADY = 1'b1;
    cmd(STAMP);
    cmd(HOLD);
    check("idle_ignores_valid", 64'(outTVALID), 64'd0);
    check("idle_ignores_done", 64'(done), 64'd1);

    // Pending beat survives HOLD until READY
    do_start();
    check("start_clears_overflow", 64'(overflow), 64'd0);
    check("start_clears_dropcount", 64'(dropCount), 64'd0);
    outTREADY = 1'b0;
    first = 64'(cyc);
    stamp(1);
    stamp(1);
    cmd(HOLD);
    for (int i = 0; i < 3; i++) begin
      check("pend_valid", 64'(outTVALID), 64'd1);
      check("pend_data", outTDATA, first);
      step();
    end
    outTREADY = 1'b1;
    step();
    outTREADY = 1'b0;
    check("held_after_pend", 64'(outTVALID), 64'd0);
    check("held_one_left", 64'(exp_q.size()), 64'd1);
    outTREADY = 1'b1;
    cmd(RELEASE);
    drain_wait(10);
    cmd(FINISH);
    wait_done(10);

    // Reset mid-DRAIN with 2 entries left
    do_start();
    outTREADY = 1'b0;
    cmd(HOLD);
    for (int i = 0; i < 6; i++) stamp(i < 4);
    check("ovf_before_rst", 64'(overflow), 64'd1);
    cmd(FINISH);
    outTREADY = 1'b1;
    step();
    step();
    outTREADY = 1'b0;
    check("mid_drain_not_done", 64'(done), 64'd0);
    check("mid_drain_valid", 64'(outTVALID), 64'd1);
    check("mid_drain_left", 64'(exp_q.size()), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_done", 64'(done), 64'd1);
    check("arst_valid", 64'(outTVALID), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_dropcount", 64'(dropCount), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    outTREADY = 1'b1;
    do_start();
    stamp(1);
    check("restart_data", outTDATA, 64'd0);
    drain_wait(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
